// File: rtl/instruction_encoder_pkg.sv
// rtl/instruction_encoder_pkg.sv - shared widths, field positions, type codes and FSM states for the instruction encoder
package instruction_encoder_pkg;

    localparam int INSTRUCTION_WIDTH   = 40;
    localparam int OPCODE_WIDTH        = 6;
    localparam int VALUE_WIDTH         = 8;
    localparam int ADDRESS_FIELD_WIDTH = 8;
    localparam int TYPE_FIELD_WIDTH    = 2;

    // Field positions for the default word width (msb of each field).
    localparam int OPCODE_MSB      = INSTRUCTION_WIDTH - 3;
    localparam int ADDRESS1_MSB    = INSTRUCTION_WIDTH - 9;
    localparam int ADDRESS2_MSB    = INSTRUCTION_WIDTH - 17;
    localparam int ADDRESS_OUT_MSB = INSTRUCTION_WIDTH - 25;
    localparam int ADDRESS1_TYPE_MSB = 5;
    localparam int ADDRESS2_TYPE_MSB = 3;
    localparam int OUT_TYPE_MSB      = 1;

    // Operand type encodings.
    localparam logic [1:0] TYPE_REGISTER  = 2'b00;
    localparam logic [1:0] TYPE_MEMORY    = 2'b01;
    localparam logic [1:0] TYPE_INDIRECT  = 2'b10;
    localparam logic [1:0] TYPE_IMMEDIATE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } encoder_state_e;

endpackage

// File: rtl/instruction_packer.sv
// rtl/instruction_packer.sv - combinational packing of decoded fields into one instruction word
module instruction_packer #(
    parameter int INSTRUCTION_WIDTH = instruction_encoder_pkg::INSTRUCTION_WIDTH,
    parameter int OPCODE_WIDTH      = instruction_encoder_pkg::OPCODE_WIDTH,
    parameter int VALUE_WIDTH       = instruction_encoder_pkg::VALUE_WIDTH
) (
    input  logic [OPCODE_WIDTH-1:0]      opCode,
    input  logic [7:0]                   address1In,
    input  logic [7:0]                   address2In,
    input  logic [7:0]                   addressOut,
    input  logic [1:0]                   address1Type,
    input  logic [1:0]                   address2Type,
    input  logic [1:0]                   outType,
    input  logic [VALUE_WIDTH-1:0]       instructionValue,
    output logic [INSTRUCTION_WIDTH-1:0] instructionWord
);
    import instruction_encoder_pkg::*;

    // Field msbs follow the word width so a wider word only grows the zero gap above the type bits.
    localparam int op_msb  = INSTRUCTION_WIDTH - 3;
    localparam int a1_msb  = INSTRUCTION_WIDTH - 9;
    localparam int a2_msb  = INSTRUCTION_WIDTH - 17;
    localparam int out_msb = INSTRUCTION_WIDTH - 25;

    // Immediate operands reuse the address2 slot, so the value replaces address2In there.
    always_comb begin
        instructionWord                = '0;
        instructionWord[op_msb -: OPCODE_WIDTH] = opCode;
        instructionWord[a1_msb -: 8]   = address1In;
        if (address2Type == TYPE_IMMEDIATE) begin
            instructionWord[a2_msb -: 8] = instructionValue;
        end else begin
            instructionWord[a2_msb -: 8] = address2In;
        end
        instructionWord[out_msb -: 8]  = addressOut;
        instructionWord[5:4]           = address1Type;
        instructionWord[3:2]           = address2Type;
        instructionWord[1:0]           = outType;
    end

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - accepts field bundles and writes packed instruction words into program memory
module instruction_encoder #(
    parameter int INSTRUCTION_WIDTH = instruction_encoder_pkg::INSTRUCTION_WIDTH,
    parameter int OPCODE_WIDTH      = instruction_encoder_pkg::OPCODE_WIDTH,
    parameter int VALUE_WIDTH       = instruction_encoder_pkg::VALUE_WIDTH,
    parameter int PROG_ADDR_WIDTH   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PROG_ADDR_WIDTH-1:0]   baseAddress,
    input  logic [PROG_ADDR_WIDTH:0]     programLength,
    input  logic                         fieldsValid,
    output logic                         fieldsReady,
    input  logic [OPCODE_WIDTH-1:0]      opCode,
    input  logic [7:0]                   address1In,
    input  logic [7:0]                   address2In,
    input  logic [7:0]                   addressOut,
    input  logic [1:0]                   address1Type,
    input  logic [1:0]                   address2Type,
    input  logic [1:0]                   outType,
    input  logic [VALUE_WIDTH-1:0]       instructionValue,
    output logic                         memWriteEnable,
    output logic [PROG_ADDR_WIDTH-1:0]   memWriteAddress,
    output logic [INSTRUCTION_WIDTH-1:0] memWriteData,
    input  logic                         memReady,
    output logic                         busy,
    output logic                         done
);
    import instruction_encoder_pkg::*;

    localparam logic [PROG_ADDR_WIDTH-1:0] ptr_one = PROG_ADDR_WIDTH'(1);
    localparam logic [PROG_ADDR_WIDTH:0]   cnt_one = (PROG_ADDR_WIDTH + 1)'(1);

    encoder_state_e                 state;
    encoder_state_e                 state_next;
    logic [PROG_ADDR_WIDTH-1:0]     pointer;
    logic [PROG_ADDR_WIDTH:0]       remaining;
    logic [INSTRUCTION_WIDTH-1:0]   packed_word;
    logic                           accept;

    instruction_packer #(
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
        .OPCODE_WIDTH      (OPCODE_WIDTH),
        .VALUE_WIDTH       (VALUE_WIDTH)
    ) u_packer (
        .opCode           (opCode),
        .address1In       (address1In),
        .address2In       (address2In),
        .addressOut       (addressOut),
        .address1Type     (address1Type),
        .address2Type     (address2Type),
        .outType          (outType),
        .instructionValue (instructionValue),
        .instructionWord  (packed_word)
    );

    // fieldsReady is only ever high in LOAD, so this also gates bundles seen in any other state.
    assign accept = fieldsValid && fieldsReady;

    // State register; reset abandons any load in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the handshake and status outputs that depend only on state.
    always_comb begin
        state_next  = state;
        fieldsReady = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (programLength == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                busy = 1'b1;
                // One-deep output register: refill in the same cycle the memory drains it.
                fieldsReady = !memWriteEnable || memReady;
                if (fieldsValid && fieldsReady && (remaining == cnt_one)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (memWriteEnable && memReady) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Load bookkeeping and the write-port output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer         <= '0;
            remaining       <= '0;
            memWriteEnable  <= 1'b0;
            memWriteAddress <= '0;
            memWriteData    <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                pointer   <= baseAddress;
                remaining <= programLength;
            end
            if (accept) begin
                memWriteEnable  <= 1'b1;
                memWriteData    <= packed_word;
                memWriteAddress <= pointer;
                pointer         <= pointer + ptr_one;
                remaining       <= remaining - cnt_one;
            end else if (memWriteEnable && memReady) begin
                memWriteEnable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed self-checking bench for instruction_encoder
module tb_instruction_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  baseAddress;
    logic [8:0]  programLength;
    logic        fieldsValid;
    logic        fieldsReady;
    logic [5:0]  opCode;
    logic [7:0]  address1In, address2In, addressOut;
    logic [1:0]  address1Type, address2Type, outType;
    logic [7:0]  instructionValue;
    logic        memWriteEnable;
    logic [7:0]  memWriteAddress;
    logic [39:0] memWriteData;
    logic        memReady;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]  wr_addr_q[$];
    logic [39:0] wr_data_q[$];
    int          last_wr_cyc = 0;
    int          done_count  = 0;
    bit          fr_seen     = 1'b0;
    int          start_cyc   = 0;

    instruction_encoder dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .baseAddress      (baseAddress),
        .programLength    (programLength),
        .fieldsValid      (fieldsValid),
        .fieldsReady      (fieldsReady),
        .opCode           (opCode),
        .address1In       (address1In),
        .address2In       (address2In),
        .addressOut       (addressOut),
        .address1Type     (address1Type),
        .address2Type     (address2Type),
        .outType          (outType),
        .instructionValue (instructionValue),
        .memWriteEnable   (memWriteEnable),
        .memWriteAddress  (memWriteAddress),
        .memWriteData     (memWriteData),
        .memReady         (memReady),
        .busy             (busy),
        .done             (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Inputs only move 1ns after a rising edge, so the falling edge sees what the next rising edge will.
    always @(negedge clock) begin
        if (!reset) begin
            if (memWriteEnable && memReady) begin
                wr_addr_q.push_back(memWriteAddress);
                wr_data_q.push_back(memWriteData);
                last_wr_cyc = cyc;
            end
            if (done) done_count = done_count + 1;
            if (fieldsReady) fr_seen = 1'b1;
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        fr_seen = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] base, input logic [8:0] len);
        @(posedge clock); #1;
        baseAddress   = base;
        programLength = len;
        start         = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send(input logic [5:0] op, input logic [7:0] a1, input logic [7:0] a2,
                        input logic [7:0] ao, input logic [1:0] t1, input logic [1:0] t2,
                        input logic [1:0] to, input logic [7:0] val);
        bit ok;
        ok = 1'b0;
        opCode = op; address1In = a1; address2In = a2; addressOut = ao;
        address1Type = t1; address2Type = t2; outType = to; instructionValue = val;
        fieldsValid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (fieldsReady) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock); #1;
        fieldsValid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_accept: fieldsReady=%0b never high, required 1 within 50 cycles", fieldsReady);
        end
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_done_seen: done=%0b, required 1 within 60 cycles", tag, done);
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_width: done=%0b one cycle later, required 0", tag, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; baseAddress = '0; programLength = '0; fieldsValid = 1'b0;
        opCode = '0; address1In = '0; address2In = '0; addressOut = '0;
        address1Type = '0; address2Type = '0; outType = '0; instructionValue = '0;
        memReady = 1'b1;
        #12;
        n_checks++;
        if ({fieldsReady, memWriteEnable, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: ready/we/busy/done=%b, required 0000",
                     {fieldsReady, memWriteEnable, busy, done});
        end
        n_checks++;
        if ({memWriteAddress, memWriteData} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%h data=%h, required 00 / 0000000000", memWriteAddress, memWriteData);
        end
        @(negedge clock);
        reset = 1'b0;
        fieldsValid = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({fieldsReady, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_ignores_valid: ready/busy=%b, required 00", {fieldsReady, busy});
        end
        fieldsValid = 1'b0;
    endtask

    task automatic test_pack(input logic [7:0] base);
        clear_log();
        do_start(base, 9'd1);
        send(6'h2A, 8'h03, 8'h05, 8'h07, 2'b01, 2'b00, 2'b10, 8'h00);
        wait_done("pack");
        n_checks++;
        if (wr_addr_q.size() !== 1) begin
            n_fail++;
            $display("FAIL pack_count: writes=%0d, required 1", wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[0] !== base || wr_data_q[0] !== 40'h2A03050712) begin
                n_fail++;
                $display("FAIL pack_word: addr=%h data=%h, required %h / 2a03050712", wr_addr_q[0], wr_data_q[0], base);
            end
        end
        n_checks++;
        if (done_count <= 0 || (cyc - 1) !== (last_wr_cyc + 1)) begin
            n_fail++;
            $display("FAIL pack_done_timing: done cycle=%0d, required %0d", cyc - 1, last_wr_cyc + 1);
        end
    endtask

    task automatic test_immediate();
        clear_log();
        do_start(8'h40, 9'd2);
        send(6'h11, 8'h22, 8'h55, 8'h44, 2'b00, 2'b11, 2'b01, 8'hC3);
        send(6'h3F, 8'hFF, 8'h81, 8'h00, 2'b11, 2'b10, 2'b11, 8'h99);
        wait_done("imm");
        n_checks++;
        if (wr_data_q.size() !== 2) begin
            n_fail++;
            $display("FAIL imm_count: writes=%0d, required 2", wr_data_q.size());
        end else begin
            n_checks++;
            if (wr_data_q[0] !== 40'h1122C3440D || wr_data_q[0][23:16] !== 8'hC3) begin
                n_fail++;
                $display("FAIL imm_value: data=%h, required 1122c3440d", wr_data_q[0]);
            end
            n_checks++;
            if (wr_data_q[1] !== 40'h3FFF81003B || wr_addr_q[1] !== 8'h41) begin
                n_fail++;
                $display("FAIL imm_non_immediate: addr=%h data=%h, required 41 / 3fff81003b", wr_addr_q[1], wr_data_q[1]);
            end
        end
    endtask

    task automatic send_set(input int i);
        case (i)
            0: send(6'h01, 8'h10, 8'h20, 8'h30, 2'b00, 2'b00, 2'b00, 8'h00);
            1: send(6'h02, 8'h11, 8'h21, 8'h31, 2'b01, 2'b01, 2'b01, 8'h00);
            2: send(6'h03, 8'h12, 8'h22, 8'h32, 2'b10, 2'b10, 2'b10, 8'h77);
            default: send(6'h04, 8'h13, 8'h23, 8'h33, 2'b11, 2'b11, 2'b11, 8'hEE);
        endcase
    endtask

    task automatic test_back_pressure();
        logic [39:0] exp_data[4];
        exp_data[0] = 40'h0110203000;
        exp_data[1] = 40'h0211213115;
        exp_data[2] = 40'h031222322A;
        exp_data[3] = 40'h0413EE333F;
        clear_log();
        do_start(8'h20, 9'd4);
        fork
            begin
                for (int i = 0; i < 4; i++) send_set(i);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge clock);
                    #1;
                    if (wr_addr_q.size() == 1) begin
                        seen = 1'b1;
                        break;
                    end
                end
                @(posedge clock); #1;
                memReady = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    n_checks++;
                    if (fieldsReady !== 1'b0 || memWriteEnable !== 1'b1 ||
                        memWriteAddress !== 8'h21 || memWriteData !== exp_data[1]) begin
                        n_fail++;
                        $display("FAIL bp_hold: ready=%0b we=%0b addr=%h data=%h, required 0 1 21 %h",
                                 fieldsReady, memWriteEnable, memWriteAddress, memWriteData, exp_data[1]);
                    end
                end
                @(posedge clock); #1;
                memReady = 1'b1;
                n_checks++;
                if (!seen) begin
                    n_fail++;
                    $display("FAIL bp_first_write: writes=%0d, required 1 within 50 cycles", wr_addr_q.size());
                end
            end
        join
        wait_done("bp");
        n_checks++;
        if (wr_addr_q.size() !== 4) begin
            n_fail++;
            $display("FAIL bp_count: writes=%0d, required 4", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_addr_q[i] !== 8'(8'h20 + i) || wr_data_q[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL bp_write%0d: addr=%h data=%h, required %h / %h",
                             i, wr_addr_q[i], wr_data_q[i], 8'(8'h20 + i), exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_addr[3];
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00;
        clear_log();
        do_start(8'hFE, 9'd3);
        for (int i = 0; i < 3; i++) send_set(i);
        wait_done("wrap");
        n_checks++;
        if (wr_addr_q.size() !== 3) begin
            n_fail++;
            $display("FAIL wrap_count: writes=%0d, required 3", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wr_addr_q[i] !== exp_addr[i]) begin
                    n_fail++;
                    $display("FAIL wrap_addr%0d: addr=%h, required %h", i, wr_addr_q[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_zero_length();
        clear_log();
        fieldsValid = 1'b1;
        do_start(8'h33, 9'd0);
        @(negedge clock);
        n_checks++;
        if ({done, busy, fieldsReady} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_done: done/busy/ready=%b, required 100", {done, busy, fieldsReady});
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done_width: done=%0b, required 0", done);
        end
        repeat (3) @(negedge clock);
        fieldsValid = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (wr_addr_q.size() !== 0 || fr_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_no_write: writes=%0d ready_seen=%0b, required 0 / 0", wr_addr_q.size(), fr_seen);
        end
    endtask

    task automatic test_reset_mid_load();
        int done_before;
        clear_log();
        do_start(8'h50, 9'd5);
        send_set(0);
        send_set(1);
        n_checks++;
        if (wr_addr_q.size() !== 1 || memWriteEnable !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_reset: writes=%0d we=%0b, required 1 / 1", wr_addr_q.size(), memWriteEnable);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({fieldsReady, memWriteEnable, busy, done, memWriteAddress, memWriteData} !== 52'h0) begin
            n_fail++;
            $display("FAIL mid_async_clear: ready=%0b we=%0b busy=%0b done=%0b addr=%h data=%h, required all 0",
                     fieldsReady, memWriteEnable, busy, done, memWriteAddress, memWriteData);
        end
        done_before = done_count;
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        n_checks++;
        if (wr_addr_q.size() !== 1 || done_count !== done_before || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_abandon: writes=%0d dones=%0d busy=%0b, required 1 / %0d / 0",
                     wr_addr_q.size(), done_count, busy, done_before);
        end
        test_pack(8'h60);
    endtask

    initial begin
        test_reset();
        test_pack(8'h10);
        test_immediate();
        test_back_pressure();
        test_wrap();
        test_zero_length();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
